mips_multicycle: RTL and testbench
==================================

# mips_multicycle

Multicycle MIPS core: successor to the single-cycle `mips` top, replacing its separate instruction/data ports with one shared memory port that has a wait-state handshake. A state machine sequences fetch, decode, execute, memory and writeback over several cycles, reusing one ALU. The reset PC and the illegal-instruction policy are parameters. The core sits between the testbench/SoC top and a unified instruction+data memory.

## Interface

- `RESET_PC`, default 32'h0000_0000, PC loaded on reset.
- `HALT_ON_ILLEGAL`, default 1. If 1, an unsupported opcode/funct enters HALT; if 0, it retires as a NOP.
- `clk` in 1: the single clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-low (0 = in reset).
- `mem_addr` out 32: byte address for the current access.
- `mem_re` out 1: read request (fetch or lw).
- `mem_we` out 1: write request (sw).
- `mem_wdata` out 32: store data, valid while `mem_we`=1.
- `mem_rdata` in 32: read data, sampled only in a cycle where `mem_ready`=1.
- `mem_ready` in 1: access completes this cycle.
- `retire` out 1: one-cycle pulse in the final cycle of each instruction.
- `halted` out 1: core is in HALT.

## Operation

- Supported instructions:
  - R-type (op 000000) with funct add 100000, sub 100010, and 100100, or 100101, slt 101010 (signed).
  - lw 100011, sw 101011, beq 000100, bne 000101, addi 001000, j 000010.
- Anything else, including an unknown R-type funct, is illegal.
- Register file: 32×32. `$0` reads 0 and ignores writes. All registers clear to 0 on reset.
- State machine states:
  - FETCH: `mem_re`=1, `mem_addr`=PC. While `mem_ready`=0, stay and hold outputs. When `mem_ready`=1, latch IR, set PC=PC+4, go to DECODE.
  - DECODE: read A=rs and B=rt. Compute ALUOut = PC + (signext(imm)<<2). Dispatch by opcode:
    - lw/sw → MEMADR
    - R-type → EXEC
    - addi → ADDIEX
    - beq/bne → BRANCH
    - j → JUMP
    - illegal → HALT if `HALT_ON_ILLEGAL`=1, else FETCH with `retire`=1.
  - MEMADR: ALUOut = A + signext(imm). Go to MEMRD (lw) or MEMWR (sw).
  - MEMRD: `mem_re`=1, `mem_addr`=ALUOut. Wait for `mem_ready`, then latch MDR and go to MEMWB.
  - MEMWB: rt = MDR; `retire`; go to FETCH.
  - MEMWR: `mem_we`=1, `mem_addr`=ALUOut, `mem_wdata`=B. Wait for `mem_ready`; on completion `retire` and go to FETCH.
  - EXEC: ALUOut = A op B. Go to ALUWB.
  - ALUWB: rd = ALUOut; `retire`; go to FETCH.
  - ADDIEX: ALUOut = A + signext(imm). Go to ADDIWB.
  - ADDIWB: rt = ALUOut; `retire`; go to FETCH.
  - BRANCH: if (A==B) for beq, or (A!=B) for bne, PC = ALUOut. `retire`; go to FETCH.
  - JUMP: PC = {PC[31:28], IR[25:0], 2'b00}. `retire`; go to FETCH.
  - HALT: absorbing; `halted`=1; no memory requests. Exit only via reset.
- Arithmetic is 32-bit modulo 2^32 with no overflow trap; add/sub/addi wrap silently. slt yields 1 or 0.
- PC wraps from FFFF_FFFC to 0.
- No unaligned-address check; `mem_addr` carries the address unmodified.

## Timing

- While `reset`=0, outputs are forced low asynchronously: `mem_re`=0, `mem_we`=0, `retire`=0, `halted`=0, `mem_addr`=RESET_PC, `mem_wdata`=0. State=FETCH, PC=RESET_PC.
- First fetch request appears in the first cycle after `reset` rises.
- Cycle counts with `mem_ready` held at 1:
  - lw 5; sw 4; R-type 4; addi 4; beq/bne 3; j 3; illegal NOP 2.
  - Each cycle of `mem_ready`=0 during FETCH, MEMRD or MEMWR adds one cycle.
- `mem_re` and `mem_we` are never both 1.
- Request outputs are stable from the first cycle of an access through the `mem_ready` cycle, and drop the following cycle unless a new access starts.
- `mem_ready` outside FETCH/MEMRD/MEMWR is ignored.
- Register writes take effect at the rising edge ending the writeback state. A read in the next DECODE sees the new value.
- Reset asserted mid-access aborts the access immediately. No write completes unless `mem_ready`=1 was sampled before reset.

## Test plan

- Reset with `RESET_PC`=0x100 and `mem_ready`=1 → first cycle after release: `mem_re`=1, `mem_addr`=0x100; the next fetch is at 0x104.
- Program addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2; slt $4,$2,$1; sw $3,0x40($0) → write of `mem_wdata`=2 to 0x40; `retire` count is 5 after 4+4+4+4+4 cycles.
- lw $5,0x40($0) with `mem_ready` low for 3 cycles in MEMRD → `mem_addr`=0x40 held for 4 cycles; $5=2; lw totals 8 cycles.
- beq $1,$1,+2 at 0x0 → next fetch at 0xC. bne $1,$1,+2 → next fetch at 0x4. j 0x3F → next fetch at 0xFC.
- Opcode 111111 with `HALT_ON_ILLEGAL`=1 → `halted`=1 after DECODE and no further `mem_re`. With the parameter set to 0 → `retire` after 2 cycles and fetch continues at PC+4.
- Drop `reset` during MEMWR with `mem_ready`=0 → `mem_we` goes to 0 asynchronously; after release, fetch resumes at `RESET_PC` and all registers read 0.

Source files
------------

// File: rtl/mips_multicycle.sv
// mips_multicycle: multicycle MIPS core with one shared wait-stated memory port.
// One ALU is reused across FETCH/DECODE/EXEC; illegal opcodes halt or retire as NOP.
module mips_multicycle #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] mem_addr,
  output logic        mem_re,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        retire,
  output logic        halted
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC,
    ALUWB, ADDIEX, ADDIWB, BRANCH, JUMP, HALT
  } state_t;
  state_t state, next;
  logic [31:0] pc, ir, a, b, alu_out, mdr, sext, alu_a, alu_b, alu_y, wr_dat;
  logic [31:0] rf [32];
  logic [5:0] op, fn;
  logic [4:0] wr_idx;
  logic r_ok, legal, take, wr_en;
  assign op = ir[31:26];
  assign fn = ir[5:0];
  assign sext = {{16{ir[15]}}, ir[15:0]};
  assign r_ok = fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
  assign legal = (op == 6'h00 && r_ok) || op inside {6'h23, 6'h2b, 6'h04, 6'h05, 6'h08, 6'h02};
  assign take = (op == 6'h04) ? a == b : a != b;
  // FETCH computes PC+4, DECODE the branch target, later states the data path
  assign alu_a = (state == FETCH || state == DECODE) ? pc : a;
  assign alu_b = state == FETCH ? 32'd4 : state == DECODE ? {sext[29:0], 2'b00} :
                 state == EXEC ? b : sext;
  assign alu_y = state != EXEC ? alu_a + alu_b :
                 fn == 6'h22 ? alu_a - alu_b :
                 fn == 6'h24 ? alu_a & alu_b :
                 fn == 6'h25 ? alu_a | alu_b :
                 fn == 6'h2a ? {31'd0, $signed(alu_a) < $signed(alu_b)} : alu_a + alu_b;
  assign wr_en = state inside {MEMWB, ALUWB, ADDIWB};
  assign wr_idx = state == ALUWB ? ir[15:11] : ir[20:16];
  assign wr_dat = state == MEMWB ? mdr : alu_out;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= FETCH;
      pc <= RESET_PC;
      ir <= '0;
      a <= '0;
      b <= '0;
      alu_out <= '0;
      mdr <= '0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      state <= next;
      if (state == FETCH && mem_ready) begin
        ir <= mem_rdata;
        pc <= alu_y;
      end
      if (state == DECODE) begin
        a <= rf[ir[25:21]];
        b <= rf[ir[20:16]];
      end
      if (state inside {DECODE, MEMADR, EXEC, ADDIEX}) alu_out <= alu_y;
      if (state == MEMRD && mem_ready) mdr <= mem_rdata;
      if (state == BRANCH && take) pc <= alu_out;
      if (state == JUMP) pc <= {pc[31:28], ir[25:0], 2'b00};
      if (wr_en && wr_idx != 5'd0) rf[wr_idx] <= wr_dat;
    end
  always_comb begin
    next = state;
    case (state)
      FETCH:  next = mem_ready ? DECODE : FETCH;
      DECODE: next = !legal ? (HALT_ON_ILLEGAL ? HALT : FETCH) :
                     (op == 6'h23 || op == 6'h2b) ? MEMADR :
                     op == 6'h00 ? EXEC :
                     op == 6'h08 ? ADDIEX :
                     op == 6'h02 ? JUMP : BRANCH;
      MEMADR: next = op == 6'h23 ? MEMRD : MEMWR;
      MEMRD:  next = mem_ready ? MEMWB : MEMRD;
      MEMWR:  next = mem_ready ? FETCH : MEMWR;
      EXEC:   next = ALUWB;
      ADDIEX: next = ADDIWB;
      HALT:   next = HALT;
      default: next = FETCH;
    endcase
  end
  // state resets to FETCH, so only the fetch request needs gating by reset
  assign mem_re = reset && (state == FETCH || state == MEMRD);
  assign mem_we = state == MEMWR;
  assign mem_addr = state == FETCH ? pc : alu_out;
  assign mem_wdata = mem_we ? b : 32'd0;
  assign halted = state == HALT;
  assign retire = state inside {MEMWB, ALUWB, ADDIWB, BRANCH, JUMP} ||
                  (state == MEMWR && mem_ready) ||
                  (state == DECODE && !legal && !HALT_ON_ILLEGAL);
endmodule

// File: tb/tb_mips_multicycle.sv
// tb_mips_multicycle: random programs run on an ISA-level model feed a retire-time scoreboard;
// a second core with default parameters exercises halt-on-illegal.
module tb_mips_multicycle;
  typedef struct {
    logic [31:0] pc;
    int cyc;
    bit st;
    logic [31:0] sa;
    logic [31:0] sd;
    bit ld;
    logic [31:0] la;
  } exp_t;
  localparam logic [31:0] RPC = 32'h100;
  logic clk, reset, h_rst;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, h_addr, h_wdata, h_rdata;
  logic mem_re, mem_we, mem_ready, retire, halted;
  logic h_re, h_we, h_retire, h_halted;
  logic [31:0] mem [1024];
  logic [31:0] mm [1024];
  logic [31:0] prog [$];
  logic [31:0] end_pc;
  exp_t q [$];
  exp_t e;
  int n_chk = 0, n_fail = 0, ready_mode = 0;
  int cyc, waits;
  bit active = 0, pend, got_f, got_l, got_s, p_re, p_we;
  logic [31:0] p_addr, p_wd, fa, la, sa, sd;

  mips_multicycle #(.RESET_PC(RPC), .HALT_ON_ILLEGAL(1'b0)) dut (
    .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .retire(retire), .halted(halted));
  mips_multicycle hdut (
    .clk(clk), .reset(h_rst), .mem_addr(h_addr), .mem_re(h_re), .mem_we(h_we),
    .mem_wdata(h_wdata), .mem_rdata(h_rdata), .mem_ready(1'b1),
    .retire(h_retire), .halted(h_halted));

  assign mem_rdata = mem[mem_addr[11:2]];
  // addi $1,$0,7 then opcode 111111
  assign h_rdata = h_addr == 32'd0 ? 32'h2001_0007 : h_addr == 32'd4 ? 32'hFC00_0000 : 32'd0;

  initial clk = 0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    #1;
    mem_ready = ready_mode == 0 ? 1'b1 : ready_mode == 1 ? ($urandom_range(0, 3) != 0) : !mem_we;
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ii(int op, int rs, int rt, int imm);
    return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
  endfunction

  function automatic logic [31:0] rr(int rs, int rt, int rd, int fn);
    return {6'd0, rs[4:0], rt[4:0], rd[4:0], 5'd0, fn[5:0]};
  endfunction

  task automatic build_program();
    int fns [5] = '{32'h20, 32'h22, 32'h24, 32'h25, 32'h2a};
    int left, off, idx;
    for (int i = 1; i < 32; i++) prog.push_back(ii(6'h2b, 0, i, 'hD00 + 4 * i));
    prog.push_back(ii(6'h08, 0, 30, 'h800));
    prog.push_back(ii(6'h08, 0, 1, 5));
    prog.push_back(ii(6'h08, 0, 2, -3));
    prog.push_back(rr(1, 2, 3, 'h20));
    prog.push_back(rr(2, 1, 4, 'h2a));
    prog.push_back(ii(6'h2b, 0, 3, 'h40));
    prog.push_back(ii(6'h23, 0, 5, 'h40));
    prog.push_back(ii(6'h04, 1, 1, 2));
    prog.push_back(ii(6'h08, 0, 6, 111));
    prog.push_back(ii(6'h08, 0, 7, 222));
    prog.push_back(ii(6'h05, 1, 1, 2));
    for (int k = 0; k < 60; k++) begin
      left = 59 - k;
      idx = prog.size();
      off = int'($urandom_range(0, left < 3 ? left : 3));
      case ($urandom_range(0, 9))
        0, 1: prog.push_back(rr($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 29),
                                fns[$urandom_range(0, 4)]));
        2: prog.push_back(ii(6'h08, $urandom_range(0, 31), $urandom_range(0, 29), $urandom_range(0, 65535)));
        3: prog.push_back(ii(6'h23, 30, $urandom_range(0, 29), int'($urandom_range(0, 255)) * 4 - 512));
        4: prog.push_back(ii(6'h2b, 30, $urandom_range(0, 31), int'($urandom_range(0, 255)) * 4 - 512));
        5: prog.push_back(ii($urandom_range(4, 5), $urandom_range(0, 7), $urandom_range(0, 7), off));
        6: prog.push_back({6'h02, 26'((int'(RPC) + 4 * (idx + 1 + off)) >> 2)});
        7: prog.push_back($urandom_range(0, 1) ? {6'h3F, 26'($urandom)} : rr(1, 2, 3, 0));
        default: prog.push_back(ii(6'h08, 0, $urandom_range(0, 29), $urandom_range(0, 65535)));
      endcase
    end
    for (int i = 1; i < 32; i++) prog.push_back(ii(6'h2b, 0, i, 'hC00 + 4 * i));
    end_pc = RPC + 32'(4 * prog.size());
    prog.push_back({6'h02, 26'(end_pc >> 2)});
  endtask

  task automatic load_program();
    logic [31:0] v;
    for (int i = 0; i < 1024; i++) begin
      v = $urandom;
      mem[i] = v;
      mm[i] = v;
    end
    for (int i = 0; i < prog.size(); i++) begin
      mem[(RPC >> 2) + 32'(i)] = prog[i];
      mm[(RPC >> 2) + 32'(i)] = prog[i];
    end
  endtask

  // ISA-level reference: one step per instruction, pushing what each retire must show
  task automatic run_model();
    logic [31:0] r [32];
    logic [31:0] pc, ins, nx, ea, av, bv, imm;
    exp_t x;
    int guard = 0;
    for (int i = 0; i < 32; i++) r[i] = 0;
    pc = RPC;
    while (pc != end_pc && guard < 5000) begin
      guard++;
      ins = mm[pc[11:2]];
      av = r[ins[25:21]];
      bv = r[ins[20:16]];
      imm = {{16{ins[15]}}, ins[15:0]};
      x.pc = pc; x.cyc = 2; x.st = 0; x.sa = 0; x.sd = 0; x.ld = 0; x.la = 0;
      nx = pc + 4;
      case (ins[31:26])
        6'h00: begin
          x.cyc = 4;
          case (ins[5:0])
            6'h20: r[ins[15:11]] = av + bv;
            6'h22: r[ins[15:11]] = av - bv;
            6'h24: r[ins[15:11]] = av & bv;
            6'h25: r[ins[15:11]] = av | bv;
            6'h2a: r[ins[15:11]] = ($signed(av) < $signed(bv)) ? 32'd1 : 32'd0;
            default: x.cyc = 2;
          endcase
        end
        6'h23: begin ea = av + imm; x.cyc = 5; x.ld = 1; x.la = ea; r[ins[20:16]] = mm[ea[11:2]]; end
        6'h2b: begin ea = av + imm; x.cyc = 4; x.st = 1; x.sa = ea; x.sd = bv; mm[ea[11:2]] = bv; end
        6'h04, 6'h05: begin x.cyc = 3; if ((av == bv) == (ins[31:26] == 6'h04)) nx = pc + 4 + (imm << 2); end
        6'h08: begin x.cyc = 4; r[ins[20:16]] = av + imm; end
        6'h02: begin x.cyc = 3; nx = {nx[31:28], ins[25:0], 2'b00}; end
        default: ;
      endcase
      r[0] = 0;
      q.push_back(x);
      pc = nx;
    end
  endtask

  // monitor: memory side effects plus scoreboard pop on every retire
  initial forever begin
    @(negedge clk);
    if (reset && mem_we && mem_ready) mem[mem_addr[11:2]] = mem_wdata;
    if (active && reset) begin
      cyc++;
      chk("re_we_exclusive", 32'(mem_re & mem_we), 0);
      chk("not_halted", 32'(halted), 0);
      if (pend) begin
        chk("hold_re", 32'(mem_re), 32'(p_re));
        chk("hold_we", 32'(mem_we), 32'(p_we));
        chk("hold_addr", mem_addr, p_addr);
        if (p_we) chk("hold_wdata", mem_wdata, p_wd);
      end
      pend = (mem_re || mem_we) && !mem_ready;
      p_re = mem_re; p_we = mem_we; p_addr = mem_addr; p_wd = mem_wdata;
      if (pend) waits++;
      if (mem_re && mem_ready) begin
        if (!got_f) begin got_f = 1; fa = mem_addr; end
        else begin got_l = 1; la = mem_addr; end
      end
      if (mem_we && mem_ready) begin got_s = 1; sa = mem_addr; sd = mem_wdata; end
      if (retire) begin
        if (q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_retire: got retire expected none at %0t", $time);
        end else begin
          e = q.pop_front();
          chk("fetch_pc", got_f ? fa : 32'hDEAD_BEEF, e.pc);
          chk("cycles", 32'(cyc), 32'(e.cyc + waits));
          chk("store_seen", 32'(got_s), 32'(e.st));
          if (e.st) begin chk("store_addr", sa, e.sa); chk("store_data", sd, e.sd); end
          chk("load_seen", 32'(got_l), 32'(e.ld));
          if (e.ld) chk("load_addr", la, e.la);
        end
        cyc = 0; waits = 0; got_f = 0; got_l = 0; got_s = 0;
      end
    end
  end

  task automatic start_run(int mode);
    load_program();
    run_model();
    ready_mode = mode;
    cyc = 0; waits = 0; pend = 0; got_f = 0; got_l = 0; got_s = 0;
    active = 1;
    @(posedge clk);
    #2 reset = 1;
  endtask

  task automatic finish_run();
    for (int i = 0; i < 20000 && q.size() > 0; i++) @(posedge clk);
    n_chk++;
    if (q.size() > 0) begin
      n_fail++;
      $display("FAIL run_timeout: got %0d retires outstanding expected 0", q.size());
    end
    active = 0;
    q.delete();
    #2 reset = 0;
  endtask

  initial begin
    int hr, hc, hre, hwe;
    bit found;
    reset = 0;
    h_rst = 0;
    build_program();
    repeat (3) @(negedge clk);
    chk("rst_re", 32'(mem_re), 0);
    chk("rst_we", 32'(mem_we), 0);
    chk("rst_retire", 32'(retire), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_addr", mem_addr, RPC);
    chk("rst_wdata", mem_wdata, 0);
    start_run(0);
    finish_run();
    // abort a stalled store with an asynchronous reset
    load_program();
    ready_mode = 2;
    @(posedge clk);
    #2 reset = 1;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      found = mem_we;
    end
    chk("abort_reached_memwr", 32'(found), 1);
    #1 reset = 0;
    #1;
    chk("abort_we", 32'(mem_we), 0);
    chk("abort_re", 32'(mem_re), 0);
    chk("abort_addr", mem_addr, RPC);
    chk("abort_retire", 32'(retire), 0);
    repeat (2) @(posedge clk);
    start_run(1);
    finish_run();
    // halt-on-illegal core
    @(posedge clk);
    #2 h_rst = 1;
    hr = 0; hc = -1; hre = 0; hwe = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      hr += int'(h_retire);
      hwe += int'(h_we);
      if (h_halted && hc < 0) hc = i;
      if (hc >= 0 && h_re) hre++;
    end
    chk("halt_cycle", 32'(hc), 7);
    chk("halt_retires", 32'(hr), 1);
    chk("halt_no_re", 32'(hre), 0);
    chk("halt_no_we", 32'(hwe), 0);
    chk("halt_wdata", h_wdata, 0);
    chk("halt_stays", 32'(h_halted), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
